// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction controller and the datapath/memory.
// Latency: none; plain wires grouped for port convenience.
// Backpressure: none; the controller drives every cycle, the datapath always accepts.
interface cpu_controller_if;
    logic [15:0] instr;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic        shiftsel;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic        load_ir;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic        addr_sel;
    logic [1:0]  mem_cmd;
    logic        halted;

    // Controller side: reads the IR, drives every control line.
    modport master (
        input  instr,
        output readnum, writenum, write, loada, loadb, loadc, loads,
        output vsel, shift, shiftsel, asel, bsel, ALUop, sximm8, sximm5,
        output load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
    );

    // Datapath side: owns the IR, consumes every control line.
    modport slave (
        output instr,
        input  readnum, writenum, write, loada, loadb, loadc, loads,
        input  vsel, shift, shiftsel, asel, bsel, ALUop, sximm8, sximm5,
        input  load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle Moore sequencer for a 16-bit load/store CPU (fetch, decode, execute, memory).
// Latency: control outputs registered alongside state; 4 to 10 cycles from IF1 to next IF1.
// Backpressure: none; memory is assumed single-cycle so the sequencer never stalls.
module cpu_controller (
    input  logic             clk,
    input  logic             rst_n,
    cpu_controller_if.master bus
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_CALC,
        S_WRD, S_ADDR, S_LADR, S_MRD, S_WBM, S_SPASS, S_MWR, S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic [1:0] vsel;
        logic       shiftsel;
        logic       asel;
        logic       bsel;
        logic [1:0] alu_op;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Instruction fields; only meaningful once the IR has been loaded in IF2.
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    assign opcode = bus.instr[15:13];
    assign op     = bus.instr[12:11];
    assign rn     = bus.instr[10:8];
    assign rd     = bus.instr[7:5];
    assign rm     = bus.instr[2:0];

    logic is_mov_imm, is_mov_reg, is_mvn, is_alu, is_cmp, is_ldr, is_str, is_halt;
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu     = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
    assign is_str     = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt    = (opcode == 3'b111);

    // Immediates and shift code pass straight through from the IR.
    assign bus.shift  = bus.instr[4:3];
    assign bus.sximm8 = {{8{bus.instr[7]}}, bus.instr[7:0]};
    assign bus.sximm5 = {{11{bus.instr[4]}}, bus.instr[4:0]};

    // Next-state selection: fixed fetch prologue, then an opcode-directed path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_IF1;
            S_IF1:   state_d = S_IF2;
            S_IF2:   state_d = S_UPC;
            S_UPC:   state_d = S_DEC;
            S_DEC: begin
                if (is_mov_imm)                 state_d = S_WIMM;
                else if (is_mov_reg || is_mvn)  state_d = S_GETB;
                else if (is_alu || is_ldr || is_str) state_d = S_GETA;
                else if (is_halt)               state_d = S_HALT;
                else                            state_d = S_IF1;
            end
            S_WIMM:  state_d = S_IF1;
            S_GETA:  state_d = (is_ldr || is_str) ? S_ADDR : S_GETB;
            // STR only reaches GETB after its address is latched.
            S_GETB:  state_d = is_str ? S_SPASS : S_CALC;
            S_CALC:  state_d = is_cmp ? S_IF1 : S_WRD;
            S_WRD:   state_d = S_IF1;
            S_ADDR:  state_d = S_LADR;
            S_LADR:  state_d = is_ldr ? S_MRD : S_GETB;
            S_MRD:   state_d = S_WBM;
            S_WBM:   state_d = S_IF1;
            S_SPASS: state_d = S_MWR;
            S_MWR:   state_d = S_IF1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Control word for the state being entered, so outputs can be registered.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_RST: begin
                ctrl_d.reset_pc = 1'b1;
                ctrl_d.load_pc  = 1'b1;
            end
            S_IF1: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.load_ir  = 1'b1;
            end
            S_UPC:  ctrl_d.load_pc = 1'b1;
            S_WIMM: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = 2'b01;
                ctrl_d.write    = 1'b1;
            end
            S_GETA: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GETB: begin
                // STR stages the store data (Rd) through B; everything else reads Rm.
                ctrl_d.readnum = is_str ? rd : rm;
                ctrl_d.loadb   = 1'b1;
            end
            S_CALC: begin
                // MOV reg / MVN ignore A; MOV reg is an ADD of zero and shifted B.
                ctrl_d.asel   = is_mov_reg || is_mvn;
                ctrl_d.alu_op = is_mov_reg ? 2'b00 : op;
                ctrl_d.loadc  = !is_cmp;
                ctrl_d.loads  = is_cmp;
            end
            S_WRD: begin
                ctrl_d.writenum = rd;
                ctrl_d.vsel     = 2'b00;
                ctrl_d.write    = 1'b1;
            end
            S_ADDR: begin
                ctrl_d.bsel     = 1'b1;
                ctrl_d.shiftsel = 1'b1;
                ctrl_d.loadc    = 1'b1;
            end
            S_LADR: ctrl_d.load_addr = 1'b1;
            S_MRD:  ctrl_d.mem_cmd   = MEM_READ;
            S_WBM: begin
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.vsel     = 2'b11;
                ctrl_d.writenum = rd;
                ctrl_d.write    = 1'b1;
            end
            S_SPASS: begin
                ctrl_d.asel     = 1'b1;
                ctrl_d.shiftsel = 1'b1;
                ctrl_d.loadc    = 1'b1;
            end
            S_MWR:  ctrl_d.mem_cmd = MEM_WRITE;
            S_HALT: ctrl_d.halted  = 1'b1;
            default: ;
        endcase
    end

    // State and registered controls; reset wins over any state, dropping a pending store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_RST;
            ctrl_q           <= '0;
            ctrl_q.reset_pc  <= 1'b1;
            ctrl_q.load_pc   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.readnum   = ctrl_q.readnum;
    assign bus.writenum  = ctrl_q.writenum;
    assign bus.write     = ctrl_q.write;
    assign bus.loada     = ctrl_q.loada;
    assign bus.loadb     = ctrl_q.loadb;
    assign bus.loadc     = ctrl_q.loadc;
    assign bus.loads     = ctrl_q.loads;
    assign bus.vsel      = ctrl_q.vsel;
    assign bus.shiftsel  = ctrl_q.shiftsel;
    assign bus.asel      = ctrl_q.asel;
    assign bus.bsel      = ctrl_q.bsel;
    assign bus.ALUop     = ctrl_q.alu_op;
    assign bus.load_ir   = ctrl_q.load_ir;
    assign bus.load_pc   = ctrl_q.load_pc;
    assign bus.reset_pc  = ctrl_q.reset_pc;
    assign bus.load_addr = ctrl_q.load_addr;
    assign bus.addr_sel  = ctrl_q.addr_sel;
    assign bus.mem_cmd   = ctrl_q.mem_cmd;
    assign bus.halted    = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: emulates the IR, predicts every control output per cycle.
// Latency: expectations are queued ahead and consumed one per cycle at the falling edge.
// Backpressure: none; all waits are cycle-bounded.
module tb_cpu_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Named phases of instruction execution, as seen by the datapath.
    typedef enum {
        T_RST, T_IF1, T_IF2, T_UPC, T_DEC, T_WIMM, T_GETA, T_GETB_RM, T_GETB_RD,
        T_CALC, T_WRD, T_ADDR, T_LADR, T_MRD, T_WBM, T_SPASS, T_MWR, T_HALT
    } step_e;

    typedef struct packed {
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic        shiftsel;
        logic        asel;
        logic        bsel;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
        logic        load_ir;
        logic        load_pc;
        logic        reset_pc;
        logic        load_addr;
        logic        addr_sel;
        logic [1:0]  mem_cmd;
        logic        halted;
    } outs_t;

    typedef struct {
        step_e       s;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] prog_q[$];
    logic [15:0] model_ir;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          if1_at[$];
    int          wr_seen  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // What the datapath must see during a given phase, from the instruction semantics.
    function automatic outs_t expect_of(step_e s, logic [15:0] ir);
        outs_t      o   = '0;
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        o.shift  = ir[4:3];
        o.sximm8 = {{8{ir[7]}}, ir[7:0]};
        o.sximm5 = {{11{ir[4]}}, ir[4:0]};
        case (s)
            T_RST:     begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
            T_IF1:     begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; end
            T_IF2:     begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1; end
            T_UPC:     o.load_pc = 1'b1;
            T_DEC:     ;
            T_WIMM:    begin o.writenum = ir[10:8]; o.vsel = 2'b01; o.write = 1'b1; end
            T_GETA:    begin o.readnum = ir[10:8]; o.loada = 1'b1; end
            T_GETB_RM: begin o.readnum = ir[2:0]; o.loadb = 1'b1; end
            T_GETB_RD: begin o.readnum = ir[7:5]; o.loadb = 1'b1; end
            T_CALC: begin
                o.asel   = (opc == 3'b110) || (op == 2'b11);
                o.alu_op = (opc == 3'b110) ? 2'b00 : op;
                if (opc == 3'b101 && op == 2'b01) o.loads = 1'b1;
                else                              o.loadc = 1'b1;
            end
            T_WRD:     begin o.writenum = ir[7:5]; o.write = 1'b1; end
            T_ADDR:    begin o.bsel = 1'b1; o.shiftsel = 1'b1; o.loadc = 1'b1; end
            T_LADR:    o.load_addr = 1'b1;
            T_MRD:     o.mem_cmd = 2'b01;
            T_WBM:     begin o.mem_cmd = 2'b01; o.vsel = 2'b11; o.writenum = ir[7:5]; o.write = 1'b1; end
            T_SPASS:   begin o.asel = 1'b1; o.shiftsel = 1'b1; o.loadc = 1'b1; end
            T_MWR:     o.mem_cmd = 2'b10;
            T_HALT:    o.halted = 1'b1;
            default:   ;
        endcase
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.readnum   = bus.readnum;   o.writenum = bus.writenum; o.write  = bus.write;
        o.loada     = bus.loada;     o.loadb    = bus.loadb;    o.loadc  = bus.loadc;
        o.loads     = bus.loads;     o.vsel     = bus.vsel;     o.shift  = bus.shift;
        o.shiftsel  = bus.shiftsel;  o.asel     = bus.asel;     o.bsel   = bus.bsel;
        o.alu_op    = bus.ALUop;     o.sximm8   = bus.sximm8;   o.sximm5 = bus.sximm5;
        o.load_ir   = bus.load_ir;   o.load_pc  = bus.load_pc;  o.reset_pc = bus.reset_pc;
        o.load_addr = bus.load_addr; o.addr_sel = bus.addr_sel; o.mem_cmd  = bus.mem_cmd;
        o.halted    = bus.halted;
        return o;
    endfunction

    task automatic push_step(input step_e s, input logic [15:0] ir);
        exp_t e;
        e.s  = s;
        e.ir = ir;
        exp_q.push_back(e);
    endtask

    // Queue the full cycle sequence of one instruction; fetch cycles still show the old IR.
    task automatic push_instr(input logic [15:0] ir, input int drop, input int nhalt);
        step_e st[$];
        push_step(T_IF1, model_ir);
        push_step(T_IF2, model_ir);
        model_ir = ir;
        prog_q.push_back(ir);
        st = '{T_UPC, T_DEC};
        case ({ir[15:13], ir[12:11]})
            5'b110_10:            st.push_back(T_WIMM);
            5'b110_00, 5'b101_11: begin st.push_back(T_GETB_RM); st.push_back(T_CALC); st.push_back(T_WRD); end
            5'b101_00, 5'b101_10: begin st.push_back(T_GETA); st.push_back(T_GETB_RM); st.push_back(T_CALC); st.push_back(T_WRD); end
            5'b101_01:            begin st.push_back(T_GETA); st.push_back(T_GETB_RM); st.push_back(T_CALC); end
            5'b011_00:            begin st.push_back(T_GETA); st.push_back(T_ADDR); st.push_back(T_LADR);
                                        st.push_back(T_MRD); st.push_back(T_WBM); end
            5'b100_00:            begin st.push_back(T_GETA); st.push_back(T_ADDR); st.push_back(T_LADR);
                                        st.push_back(T_GETB_RD); st.push_back(T_SPASS); st.push_back(T_MWR); end
            default: if (ir[15:13] == 3'b111) repeat (nhalt) st.push_back(T_HALT);
        endcase
        repeat (drop) void'(st.pop_back());
        foreach (st[i]) push_step(st[i], ir);
    endtask

    // Returns at posedge+2 in the first cycle that has no queued expectation.
    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left after %0d cycles, want 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // One-cycle reset pulse starting from a known current phase.
    task automatic pulse_reset(input step_e cur);
        push_step(cur, model_ir);
        rst_n = 1'b0;
        push_step(T_RST, model_ir);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Instruction register: loads the next program word on the edge that ends IF2.
    initial begin
        bus.instr = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.load_ir === 1'b1) begin
                @(posedge clk); #1;
                if (prog_q.size() > 0) bus.instr = prog_q.pop_front();
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        exp_t  e;
        outs_t want, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                want = expect_of(e.s, e.ir);
                got  = sample();
                check(e.s.name(), 64'(got), 64'(want));
            end
        end
    end

    // Fetch-start timestamps and store-command observation.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.addr_sel === 1'b1 && bus.mem_cmd === 2'b01 && bus.load_ir === 1'b0)
                if1_at.push_back(cyc);
            if (bus.mem_cmd === 2'b10) wr_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prog1[$];
        int          lat_want[$];
        outs_t       m;

        // Model pins: hand-derived values for representative phases.
        m = expect_of(T_WIMM, 16'hD105);
        check("pin_wimm", {m.writenum, m.vsel, m.write, m.sximm8}, {3'd1, 2'b01, 1'b1, 16'h0005});
        m = expect_of(T_DEC, 16'hD2FF);
        check("pin_sximm8_neg", m.sximm8, 16'hFFFF);
        m = expect_of(T_GETA, 16'hA0A1);
        check("pin_add_geta", {m.readnum, m.loada}, {3'd0, 1'b1});
        m = expect_of(T_GETB_RM, 16'hA0A1);
        check("pin_add_getb", {m.readnum, m.loadb}, {3'd1, 1'b1});
        m = expect_of(T_CALC, 16'hA0A1);
        check("pin_add_calc", {m.alu_op, m.loadc, m.asel}, {2'b00, 1'b1, 1'b0});
        m = expect_of(T_WRD, 16'hA0A1);
        check("pin_add_wrd", {m.writenum, m.vsel, m.write}, {3'd5, 2'b00, 1'b1});
        m = expect_of(T_CALC, 16'hA923);
        check("pin_cmp_calc", {m.loads, m.loadc, m.alu_op}, {1'b1, 1'b0, 2'b01});
        m = expect_of(T_DEC, 16'h61BF);
        check("pin_sximm5_neg", m.sximm5, 16'hFFFF);
        m = expect_of(T_WBM, 16'h61BF);
        check("pin_ldr_wbm", {m.mem_cmd, m.vsel, m.writenum}, {2'b01, 2'b11, 3'd5});
        m = expect_of(T_MWR, 16'h82DF);
        check("pin_str_mwr", {m.mem_cmd, m.addr_sel}, {2'b10, 1'b0});

        // Reset held for two edges, then a mixed program ending in HALT.
        rst_n    = 1'b0;
        model_ir = 16'h0000;
        @(posedge clk); #2;
        push_step(T_RST, model_ir);
        @(posedge clk); #2;
        push_step(T_RST, model_ir);
        rst_n = 1'b1;
        if1_at.delete();
        prog1 = '{16'hD105, 16'hD2FF, 16'hA0A1, 16'hA923, 16'hC048, 16'hB8F2,
                  16'hB43B, 16'h0000, 16'hC800, 16'h61BF, 16'h82DF, 16'hE000};
        foreach (prog1[i]) push_instr(prog1[i], 0, 20);
        drain(1000);

        // IF1-to-IF1 latency of each instruction before the HALT.
        lat_want = '{5, 5, 8, 7, 7, 7, 8, 4, 4, 9, 10};
        foreach (lat_want[i]) begin
            if (if1_at.size() > i + 1)
                check($sformatf("latency_%0d", i), 64'(if1_at[i+1] - if1_at[i]), 64'(lat_want[i]));
            else
                check($sformatf("latency_%0d_missing", i), 64'(if1_at.size()), 64'(i + 2));
        end

        // Leave HALT through a one-cycle reset, then abort a store in SPASS.
        pulse_reset(T_HALT);
        wr_seen = 0;
        push_instr(16'h82DF, 2, 0);
        drain(200);
        pulse_reset(T_SPASS);
        push_instr(16'hE000, 0, 3);
        drain(200);
        check("store_abandoned_writes", 64'(wr_seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have no parameters; all ports SHALL be as below.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 instr  in  16  current IR contents: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
REQ-005 readnum, writenum  out  3 each  regfile read/write register index.
REQ-006 write, loada, loadb, loadc, loads  out  1 each  regfile write enable; A, B, C and status load enables.
REQ-007 vsel  out  2  writeback select: 00=C, 01=sximm8, 10=PC, 11=mdata.
REQ-008 shift  out  2  shift code (= instr[4:3]); shiftsel  out  1  1 forces shift 00.
REQ-009 asel, bsel  out  1 each  A-operand zero select; B-operand sximm5 select.
REQ-010 ALUop  out  2  ALU operation.
REQ-011 sximm8, sximm5  out  16 each  sign-extended imm8/imm5, combinational from instr.
REQ-012 load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1 each  IR load; PC load; PC clear; data-address load; 1=memory address from PC.
REQ-013 mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE.
REQ-014 halted  out  1  high while in HALT.

Function
REQ-015 Moore FSM; states: RST, IF1, IF2, UPC, DEC, WIMM, GETA, GETB, CALC, WRD, ADDR, LADR, MRD, WBM, SPASS, MWR, HALT.
REQ-016 Outputs SHALL be 0 in every state except where listed below; shift SHALL always equal instr[4:3].
REQ-017 RST: reset_pc=1, load_pc=1 -> IF1. IF1: addr_sel=1, mem_cmd=01 -> IF2. IF2: IF1 outputs plus load_ir=1 -> UPC. UPC: load_pc=1 -> DEC. DEC: no outputs, dispatch.
REQ-018 Dispatch: 110/10 MOV imm -> WIMM; 110/00 MOV reg and 101/11 MVN -> GETB; 101/00 ADD, 101/01 CMP, 101/10 AND -> GETA; 011/00 LDR and 100/00 STR -> GETA; 111 HALT -> HALT; any other encoding -> IF1 (no-op).
REQ-019 WIMM: writenum=Rn, vsel=01, write=1 -> IF1.
REQ-020 GETA: readnum=Rn, loada=1 -> GETB for ALU ops; -> ADDR for LDR/STR.
REQ-021 GETB: readnum=Rm, loadb=1 -> CALC; for STR: readnum=Rd, loadb=1 -> SPASS.
REQ-022 CALC: shiftsel=0, bsel=0; asel=1 for MOV reg/MVN, else 0; ALUop=00 for MOV reg, else op; loadc=1 except CMP, which asserts loads=1 instead; CMP -> IF1, others -> WRD.
REQ-023 WRD: writenum=Rd, vsel=00, write=1 -> IF1.
REQ-024 ADDR: asel=0, bsel=1, shiftsel=1, ALUop=00, loadc=1 -> LADR. LADR: load_addr=1 -> MRD (LDR) or GETB (STR).
REQ-025 MRD: addr_sel=0, mem_cmd=01 -> WBM. WBM: mem_cmd=01, vsel=11, writenum=Rd, write=1 -> IF1.
REQ-026 SPASS: asel=1, bsel=0, shiftsel=1, ALUop=00, loadc=1 -> MWR. MWR: addr_sel=0, mem_cmd=10 -> IF1.
REQ-027 HALT: halted=1, all other outputs 0; SHALL remain in HALT until rst_n=0.
REQ-028 Latency IF1-to-next-IF1: MOV imm 5, CMP 7, MOV reg/MVN 7, ADD/AND 8, LDR 9, STR 10 cycles.
REQ-029 instr SHALL be sampled only in states after IF2; it changes only via load_ir.

Reset
REQ-030 rst_n=0 at any posedge, in any state including mid-instruction or HALT, SHALL force RST next cycle; a memory write in progress is abandoned; RST is held while rst_n=0.

Verification
REQ-031 Reset then instr=16'hD105 (MOV R1,#5) -> RST,IF1,IF2,UPC,DEC,WIMM with writenum=1, vsel=01, write=1, sximm8=0x0005; back in IF1 at cycle 6.
REQ-032 instr=16'hD2FF -> sximm8=0xFFFF; instr=16'hA0A1 (ADD R5,R0,R1) -> GETA readnum=0, GETB readnum=1, CALC ALUop=00 loadc=1, WRD writenum=5.
REQ-033 instr=16'hA9xx (CMP) -> CALC loads=1, loadc=0, no write cycle, returns to IF1.
REQ-034 LDR then STR with imm5=5'b11111 -> sximm5=0xFFFF; LDR sequence ends WBM with mem_cmd=01, vsel=11; STR reaches MWR with mem_cmd=10, addr_sel=0.
REQ-035 instr=16'hE000 -> HALT, halted=1 for 20 cycles; rst_n=0 one cycle -> RST, halted=0.
REQ-036 rst_n=0 asserted in SPASS -> next state RST, mem_cmd never 10.
